// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_pkg
// Brief    : FunSel operation codes and flag bit indices for register_nbit_flagged.
// Revision : 1.0
// ============================================================================
package reg_pkg;

  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;
  localparam logic [2:0] FS_CLR  = 3'b011;
  localparam logic [2:0] FS_SHL  = 3'b100;
  localparam logic [2:0] FS_ASR  = 3'b101;
  localparam logic [2:0] FS_ROL  = 3'b110;
  localparam logic [2:0] FS_ROR  = 3'b111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_O = 3;
  localparam int FLAG_W = 4;

endpackage
`default_nettype wire

// File: rtl/register_nbit_nextval.sv
`default_nettype none
// ============================================================================
// Module   : register_nbit_nextval
// Brief    : Combinational next-value, carry and overflow for each FunSel code.
//            Build option: REG_SATURATE_EN makes INC/DEC saturate.
// Revision : 1.0
// ============================================================================
module register_nbit_nextval
  import reg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] old,
  input  logic [WIDTH-1:0] In,
  input  logic [2:0]       FunSel,
  output logic [WIDTH-1:0] next_out,
  output logic             carry,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_all_one = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_max_pos = {1'b0, {(WIDTH-1){1'b1}}};

  logic w_at_zero;
  logic w_at_ones;

  assign w_at_zero = (old == '0);
  assign w_at_ones = (old == c_all_one);

  always_comb begin
    next_out = old;
    carry    = 1'b0;
    ovf      = 1'b0;
    case (FunSel)
      FS_DEC: begin
        carry = w_at_zero;
        ovf   = (old == c_min_neg);
`ifdef REG_SATURATE_EN
        next_out = w_at_zero ? old : old - c_one;
`else
        next_out = old - c_one;
`endif
      end
      FS_INC: begin
        carry = w_at_ones;
        ovf   = (old == c_max_pos);
`ifdef REG_SATURATE_EN
        next_out = w_at_ones ? old : old + c_one;
`else
        next_out = old + c_one;
`endif
      end
      FS_LOAD: next_out = In;
      FS_CLR:  next_out = '0;
      FS_SHL: begin
        next_out = {old[WIDTH-2:0], 1'b0};
        carry    = old[WIDTH-1];
        ovf      = old[WIDTH-1] ^ old[WIDTH-2];
      end
      FS_ASR: begin
        next_out = {old[WIDTH-1], old[WIDTH-1:1]};
        carry    = old[0];
      end
      FS_ROL: begin
        next_out = {old[WIDTH-2:0], old[WIDTH-1]};
        carry    = old[WIDTH-1];
      end
      default: begin
        next_out = {old[0], old[WIDTH-1:1]};
        carry    = old[0];
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/register_nbit_flagged.sv
`default_nettype none
// ============================================================================
// Module   : register_nbit_flagged
// Brief    : N-bit load/inc/dec/clear/shift/rotate register with registered
//            Z/N/C/O flags. Build option: REG_SATURATE_EN (saturating INC/DEC).
// Revision : 1.0
// ============================================================================
module register_nbit_flagged
  import reg_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             E,
  input  logic [2:0]       FunSel,
  input  logic [WIDTH-1:0] In,
  output logic [WIDTH-1:0] Out,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             O
);

  logic [WIDTH-1:0]  r_out;
  logic [FLAG_W-1:0] r_flags;
  logic [WIDTH-1:0]  w_next;
  logic              w_carry;
  logic              w_ovf;

  register_nbit_nextval #(
    .WIDTH (WIDTH)
  ) u_nextval (
    .old      (r_out),
    .In       (In),
    .FunSel   (FunSel),
    .next_out (w_next),
    .carry    (w_carry),
    .ovf      (w_ovf)
  );

  // Z and N come from the value being written so all flags land with Out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out   <= RESET_VALUE;
      r_flags <= '0;
    end else if (E) begin
      r_out           <= w_next;
      r_flags[FLAG_Z] <= (w_next == '0);
      r_flags[FLAG_N] <= w_next[WIDTH-1];
      r_flags[FLAG_C] <= w_carry;
      r_flags[FLAG_O] <= w_ovf;
    end
  end

  assign Out = r_out;
  assign Z   = r_flags[FLAG_Z];
  assign N   = r_flags[FLAG_N];
  assign C   = r_flags[FLAG_C];
  assign O   = r_flags[FLAG_O];

endmodule
`default_nettype wire

// File: tb/tb_register_nbit_flagged.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_nbit_flagged
// Brief    : Scoreboard bench for register_nbit_flagged (16-bit and 8-bit/5A).
// Revision : 1.0
// ============================================================================
module tb_register_nbit_flagged;
  import reg_pkg::*;

  typedef struct {
    int          cyc;
    bit          sel;
    logic [15:0] out;
    logic [3:0]  fl;
    string       name;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        E = 1'b0;
  logic [2:0]  FunSel = 3'b000;
  logic [15:0] In = 16'h0000;
  logic [15:0] out16;
  logic        z16, n16, c16, o16;
  logic [7:0]  out8;
  logic        z8, n8, c8, o8;

  int   cyc_now = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc_now <= cyc_now + 1;

  register_nbit_flagged #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut16 (
    .clock(clock), .reset_n(reset_n), .E(E), .FunSel(FunSel), .In(In),
    .Out(out16), .Z(z16), .N(n16), .C(c16), .O(o16)
  );

  register_nbit_flagged #(.WIDTH(8), .RESET_VALUE(8'h5A)) dut8 (
    .clock(clock), .reset_n(reset_n), .E(E), .FunSel(FunSel), .In(In[7:0]),
    .Out(out8), .Z(z8), .N(n8), .C(c8), .O(o8)
  );

  task automatic push(input int cyc, input bit sel, input logic [15:0] xo,
                      input logic [3:0] xf, input string nm);
    exp_t t;
    t.cyc = cyc; t.sel = sel; t.out = xo; t.fl = xf; t.name = nm;
    q.push_back(t);
  endtask

  // Flags given as {Z,N,C,O}; the check lands after the next rising edge.
  task automatic op(input logic e, input logic [2:0] fs, input logic [15:0] din,
                    input logic [15:0] xo, input logic [3:0] xf, input string nm);
    @(negedge clock);
    E = e; FunSel = fs; In = din;
    push(cyc_now + 1, 1'b0, xo, xf, nm);
  endtask

  // Monitor: pops every expectation whose edge has already happened.
  initial begin
    exp_t        t;
    logic [15:0] ao;
    logic [3:0]  af;
    forever begin
      @(negedge clock or negedge reset_n);
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc_now) begin
        t = q.pop_front();
        if (t.sel) begin ao = {8'h00, out8}; af = {z8, n8, c8, o8}; end
        else       begin ao = out16;         af = {z16, n16, c16, o16}; end
        n_vec++;
        if (ao !== t.out || af !== t.fl) begin
          n_fail++;
          $display("FAIL %s: got Out=%h ZNCO=%b, expected Out=%h ZNCO=%b",
                   t.name, ao, af, t.out, t.fl);
        end
      end
    end
  end

  initial begin
    @(negedge clock);
    push(cyc_now, 1'b0, 16'h0000, 4'b0000, "reset16");
    push(cyc_now, 1'b1, 16'h005A, 4'b0000, "reset8_5A");
    @(negedge clock);
    reset_n = 1'b1;

    op(1, FS_LOAD, 16'h1234, 16'h1234, 4'b0000, "load_1234");
    op(1, FS_INC,  16'h0000, 16'h1235, 4'b0000, "inc_1235");
    // Asynchronous reset between edges: visible before the next rising edge.
    @(negedge clock);
    E = 1'b1; FunSel = FS_INC;
    #2;
    reset_n = 1'b0;
    push(cyc_now, 1'b0, 16'h0000, 4'b0000, "async_reset16");
    push(cyc_now, 1'b1, 16'h005A, 4'b0000, "async_reset8");
    @(negedge clock);
    reset_n = 1'b1;

    op(1, FS_LOAD, 16'hFFFF, 16'hFFFF, 4'b0100, "load_FFFF");
`ifdef REG_SATURATE_EN
    op(1, FS_INC,  16'h0000, 16'hFFFF, 4'b0110, "inc_sat_FFFF");
`else
    op(1, FS_INC,  16'h0000, 16'h0000, 4'b1010, "inc_wrap_FFFF");
`endif
    op(1, FS_LOAD, 16'h7FFF, 16'h7FFF, 4'b0000, "load_7FFF");
    op(1, FS_INC,  16'h0000, 16'h8000, 4'b0101, "inc_ovf_7FFF");
    op(1, FS_DEC,  16'h0000, 16'h7FFF, 4'b0001, "dec_ovf_8000");
    op(1, FS_LOAD, 16'h8001, 16'h8001, 4'b0100, "load_8001");
    op(1, FS_ASR,  16'h0000, 16'hC000, 4'b0110, "asr_8001");
    op(1, FS_LOAD, 16'h0001, 16'h0001, 4'b0000, "load_0001");
    op(1, FS_ROR,  16'h0000, 16'h8000, 4'b0110, "ror_0001");
    op(1, FS_LOAD, 16'hC000, 16'hC000, 4'b0100, "load_C000");
    op(1, FS_SHL,  16'h0000, 16'h8000, 4'b0110, "shl_C000");
    op(1, FS_ROL,  16'h0000, 16'h0001, 4'b0010, "rol_8000");
    op(1, FS_SHL,  16'h0000, 16'h0002, 4'b0000, "shl_0001");
    op(1, FS_LOAD, 16'h4000, 16'h4000, 4'b0000, "load_4000");
    op(1, FS_SHL,  16'h0000, 16'h8000, 4'b0101, "shl_ovf_4000");
    op(1, FS_CLR,  16'hAAAA, 16'h0000, 4'b1000, "clr");
`ifdef REG_SATURATE_EN
    op(1, FS_DEC,  16'h0000, 16'h0000, 4'b1010, "dec_sat_0");
    for (int i = 0; i < 3; i++)
      op(0, FS_CLR, 16'hAAAA, 16'h0000, 4'b1010, "hold_E0");
`else
    op(1, FS_DEC,  16'h0000, 16'hFFFF, 4'b0110, "dec_wrap_0");
    for (int i = 0; i < 3; i++)
      op(0, FS_CLR, 16'hAAAA, 16'hFFFF, 4'b0110, "hold_E0");
`endif
    op(1, FS_LOAD, 16'h5555, 16'h5555, 4'b0000, "load_after_hold");

    @(negedge clock);
    E = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
